// File: rtl/hazard_forward_if.sv
// rtl/hazard_forward_if.sv - pipeline hazard/forwarding signal bundle
interface hazard_forward_if #(
    parameter int ADDR_W  = 4,
    parameter int NUM_SRC = 2
);
    logic                        id_valid;
    logic [NUM_SRC*ADDR_W-1:0]   id_src_addr;
    logic [NUM_SRC-1:0]          id_src_valid;
    logic                        id_is_mc;
    logic [ADDR_W-1:0]           ex_dst_addr;
    logic                        ex_reg_write;
    logic                        ex_mem_read;
    logic [ADDR_W-1:0]           mem_dst_addr;
    logic                        mem_reg_write;
    logic [2*NUM_SRC-1:0]        fwd_sel;
    logic                        pc_hold;
    logic                        ifid_hold;
    logic                        idex_flush;
    logic                        idex_hold;
    logic                        exmem_flush;
    logic                        busy;
    logic [15:0]                 stall_cycles;

    modport master (
        output id_valid, id_src_addr, id_src_valid, id_is_mc,
               ex_dst_addr, ex_reg_write, ex_mem_read,
               mem_dst_addr, mem_reg_write,
        input  fwd_sel, pc_hold, ifid_hold, idex_flush, idex_hold,
               exmem_flush, busy, stall_cycles
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_valid, id_is_mc,
               ex_dst_addr, ex_reg_write, ex_mem_read,
               mem_dst_addr, mem_reg_write,
        output fwd_sel, pc_hold, ifid_hold, idex_flush, idex_hold,
               exmem_flush, busy, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - load-use/multicycle stall control and operand forwarding select
module hazard_forward_unit #(
    parameter int ADDR_W   = 4,
    parameter int NUM_SRC  = 2,
    parameter int MC_LAT   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    hazard_forward_if.slave bus
);
    typedef enum logic {IDLE, MC_BUSY} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
    logic [15:0]          stall_cycles_q, stall_cycles_d;

    logic [NUM_SRC-1:0]   match_ex;
    logic [NUM_SRC-1:0]   match_mem;
    logic                 load_use;
    logic                 pc_hold, ifid_hold, idex_flush, idex_hold, exmem_flush, busy;

    // Per-source comparison against the two producer stages; address 0 is
    // excluded when it is the hardwired zero register.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        logic [ADDR_W-1:0] src;
        logic              src_live;
        assign src       = bus.id_src_addr[i*ADDR_W +: ADDR_W];
        assign src_live  = bus.id_src_valid[i] && ((ZERO_REG == 0) || (src != '0));
        assign match_ex[i]  = src_live && bus.ex_reg_write  && (src == bus.ex_dst_addr);
        assign match_mem[i] = src_live && bus.mem_reg_write && (src == bus.mem_dst_addr);
    end

    // A load in EX feeding the ID instruction can only be resolved by one bubble;
    // it is not evaluated while a multicycle op holds the pipe.
    assign load_use = !rst && (state_q == IDLE) && bus.id_valid && bus.ex_mem_read && (|match_ex);

    // Stall FSM: next state, down-counter and the combinational hold/flush controls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_flush  = 1'b0;
        idex_hold   = 1'b0;
        exmem_flush = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_use) begin
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                    idex_flush = 1'b1;
                end else if (!rst && bus.id_valid && bus.id_is_mc && (MC_LAT > 1)) begin
                    state_d = MC_BUSY;
                    cnt_d   = 8'(MC_LAT - 1);
                end
            end
            MC_BUSY: begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_hold   = 1'b1;
                exmem_flush = 1'b1;
                busy        = 1'b1;
                cnt_d       = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next forwarding select: bubble clears it, a held ID/EX keeps it, and the
    // newer EX result wins over MEM.
    always_comb begin
        fwd_sel_d = fwd_sel_q;
        if (idex_flush) begin
            fwd_sel_d = '0;
        end else if (!idex_hold) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (match_ex[i]) begin
                    fwd_sel_d[2*i +: 2] = 2'b10;
                end else if (match_mem[i]) begin
                    fwd_sel_d[2*i +: 2] = 2'b01;
                end else begin
                    fwd_sel_d[2*i +: 2] = 2'b00;
                end
            end
        end
    end

    // Saturating count of frozen-PC cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_hold && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            fwd_sel_q      <= '0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fwd_sel_q      <= fwd_sel_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.fwd_sel      = fwd_sel_q;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.pc_hold      = pc_hold;
    assign bus.ifid_hold    = ifid_hold;
    assign bus.idex_flush   = idex_flush;
    assign bus.idex_hold    = idex_hold;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - scoreboard bench for hazard_forward_unit
module tb_hazard_forward_unit;
    logic clk;
    logic rst;

    hazard_forward_if #(.ADDR_W(4), .NUM_SRC(2)) if0 ();
    hazard_forward_if #(.ADDR_W(4), .NUM_SRC(2)) if1 ();
    hazard_forward_if #(.ADDR_W(4), .NUM_SRC(2)) if2 ();

    hazard_forward_unit #(.ADDR_W(4), .NUM_SRC(2), .MC_LAT(3), .ZERO_REG(1)) u_lat3 (
        .clk(clk), .rst(rst), .bus(if0));
    hazard_forward_unit #(.ADDR_W(4), .NUM_SRC(2), .MC_LAT(1), .ZERO_REG(1)) u_lat1 (
        .clk(clk), .rst(rst), .bus(if1));
    hazard_forward_unit #(.ADDR_W(4), .NUM_SRC(2), .MC_LAT(5), .ZERO_REG(1)) u_lat5 (
        .clk(clk), .rst(rst), .bus(if2));

    assign if1.id_valid      = if0.id_valid;
    assign if1.id_src_addr   = if0.id_src_addr;
    assign if1.id_src_valid  = if0.id_src_valid;
    assign if1.id_is_mc      = if0.id_is_mc;
    assign if1.ex_dst_addr   = if0.ex_dst_addr;
    assign if1.ex_reg_write  = if0.ex_reg_write;
    assign if1.ex_mem_read   = if0.ex_mem_read;
    assign if1.mem_dst_addr  = if0.mem_dst_addr;
    assign if1.mem_reg_write = if0.mem_reg_write;
    assign if2.id_valid      = if0.id_valid;
    assign if2.id_src_addr   = if0.id_src_addr;
    assign if2.id_src_valid  = if0.id_src_valid;
    assign if2.id_is_mc      = if0.id_is_mc;
    assign if2.ex_dst_addr   = if0.ex_dst_addr;
    assign if2.ex_reg_write  = if0.ex_reg_write;
    assign if2.ex_mem_read   = if0.ex_mem_read;
    assign if2.mem_dst_addr  = if0.mem_dst_addr;
    assign if2.mem_reg_write = if0.mem_reg_write;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {pc_hold, ifid_hold, idex_flush, idex_hold, exmem_flush, busy}
    typedef struct {
        string       nm;
        int          inst;
        logic [2:0]  mask;   // {stall, ctl, fwd}
        logic [3:0]  fwd;
        logic [5:0]  ctl;
        logic [15:0] stall;
    } exp_t;

    localparam logic [5:0] CTL_NONE = 6'b000000;
    localparam logic [5:0] CTL_LU   = 6'b111000;
    localparam logic [5:0] CTL_MC   = 6'b110111;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push(input string nm, input int inst, input logic [2:0] mask,
                                 input logic [3:0] f, input logic [5:0] c, input logic [15:0] s);
        exp_t e;
        e.nm = nm; e.inst = inst; e.mask = mask; e.fwd = f; e.ctl = c; e.stall = s;
        sb.push_back(e);
    endfunction

    task automatic drive(input logic v, input logic [7:0] src, input logic [1:0] sv, input logic mc,
                         input logic [3:0] exd, input logic exw, input logic exl,
                         input logic [3:0] memd, input logic memw);
        if0.id_valid      = v;
        if0.id_src_addr   = src;
        if0.id_src_valid  = sv;
        if0.id_is_mc      = mc;
        if0.ex_dst_addr   = exd;
        if0.ex_reg_write  = exw;
        if0.ex_mem_read   = exl;
        if0.mem_dst_addr  = memd;
        if0.mem_reg_write = memw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic reset_pulse();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every sampling point drains the expectations queued for it.
    always @(negedge clk) begin
        exp_t        e;
        logic [3:0]  af;
        logic [5:0]  ac;
        logic [15:0] as_;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.inst)
                0: begin
                    af  = if0.fwd_sel;
                    ac  = {if0.pc_hold, if0.ifid_hold, if0.idex_flush, if0.idex_hold, if0.exmem_flush, if0.busy};
                    as_ = if0.stall_cycles;
                end
                1: begin
                    af  = if1.fwd_sel;
                    ac  = {if1.pc_hold, if1.ifid_hold, if1.idex_flush, if1.idex_hold, if1.exmem_flush, if1.busy};
                    as_ = if1.stall_cycles;
                end
                default: begin
                    af  = if2.fwd_sel;
                    ac  = {if2.pc_hold, if2.ifid_hold, if2.idex_flush, if2.idex_hold, if2.exmem_flush, if2.busy};
                    as_ = if2.stall_cycles;
                end
            endcase
            if (e.mask[0]) begin
                checks++;
                if (af !== e.fwd) begin
                    errors++;
                    $display("FAIL %s fwd_sel inst%0d: got %b expected %b", e.nm, e.inst, af, e.fwd);
                end
            end
            if (e.mask[1]) begin
                checks++;
                if (ac !== e.ctl) begin
                    errors++;
                    $display("FAIL %s ctl inst%0d: got %b expected %b", e.nm, e.inst, ac, e.ctl);
                end
            end
            if (e.mask[2]) begin
                checks++;
                if (as_ !== e.stall) begin
                    errors++;
                    $display("FAIL %s stall_cycles inst%0d: got %0d expected %0d", e.nm, e.inst, as_, e.stall);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        #1;
        for (int i = 0; i < 3; i++) push("reset", i, 3'b111, 4'h0, CTL_NONE, 16'd0);
        tick();
        rst = 1'b0;

        // EX forward on src0, then MEM forward on src1
        drive(1'b1, 8'h53, 2'b11, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        push("ex_fwd_ctl", 0, 3'b010, 4'h0, CTL_NONE, 16'd0);
        tick();
        push("ex_fwd", 0, 3'b001, 4'b0010, CTL_NONE, 16'd0);
        drive(1'b1, 8'h53, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1);
        tick();
        push("mem_fwd", 0, 3'b001, 4'b0100, CTL_NONE, 16'd0);

        // EX beats MEM; unread src1 never forwards
        drive(1'b1, 8'h22, 2'b01, 1'b0, 4'd2, 1'b1, 1'b0, 4'd2, 1'b1);
        tick();
        push("priority", 0, 3'b001, 4'b0010, CTL_NONE, 16'd0);

        // Zero register: no forward, no load-use stall
        drive(1'b1, 8'h00, 2'b11, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1);
        push("zero_ctl", 0, 3'b010, 4'h0, CTL_NONE, 16'd0);
        tick();
        push("zero_fwd", 0, 3'b101, 4'h0, CTL_NONE, 16'd0);

        // Load-use on src1
        drive(1'b1, 8'h47, 2'b11, 1'b0, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0);
        push("lu_stall", 0, 3'b010, 4'h0, CTL_LU, 16'd0);
        tick();
        drive(1'b1, 8'h47, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1);
        push("lu_bubble", 0, 3'b111, 4'h0, CTL_NONE, 16'd1);
        tick();
        push("lu_mem_fwd", 0, 3'b111, 4'b0100, CTL_NONE, 16'd1);
        drive_idle();
        tick();

        // Multicycle with fresh counters; MC_LAT=1 instance must never stall
        reset_pulse();
        drive(1'b1, 8'h03, 2'b01, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        push("mc_issue", 0, 3'b010, 4'h0, CTL_NONE, 16'd0);
        push("mc_issue_lat1", 1, 3'b010, 4'h0, CTL_NONE, 16'd0);
        tick();
        drive(1'b0, 8'h99, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1);
        push("mc_busy1", 0, 3'b011, 4'b0010, CTL_MC, 16'd0);
        push("mc_busy1_lat1", 1, 3'b011, 4'b0010, CTL_NONE, 16'd0);
        tick();
        push("mc_busy2", 0, 3'b111, 4'b0010, CTL_MC, 16'd1);
        push("mc_busy2_lat1", 1, 3'b011, 4'b0101, CTL_NONE, 16'd0);
        tick();
        drive_idle();
        push("mc_done", 0, 3'b111, 4'b0010, CTL_NONE, 16'd2);
        push("mc_done_lat1", 1, 3'b110, 4'h0, CTL_NONE, 16'd0);
        tick();
        push("mc_idle", 0, 3'b011, 4'h0, CTL_NONE, 16'd0);

        // Reset in the second busy cycle of the MC_LAT=5 instance
        reset_pulse();
        drive(1'b1, 8'h00, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        drive_idle();
        push("rb_busy1", 2, 3'b110, 4'h0, CTL_MC, 16'd0);
        tick();
        rst = 1'b1;
        push("rb_async", 2, 3'b111, 4'h0, CTL_NONE, 16'd0);
        push("rb_async_lat3", 0, 3'b110, 4'h0, CTL_NONE, 16'd0);
        tick();
        rst = 1'b0;
        push("rb_release", 2, 3'b111, 4'h0, CTL_NONE, 16'd0);
        tick();
        push("rb_idle", 2, 3'b111, 4'h0, CTL_NONE, 16'd0);
        tick();

        // Saturation of stall_cycles via a persistent load-use condition
        reset_pulse();
        drive(1'b1, 8'h04, 2'b01, 1'b0, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 65534; i++) tick();
        push("sat_preload", 0, 3'b110, 4'h0, CTL_LU, 16'd65534);
        for (int i = 0; i < 3; i++) begin
            tick();
            push("sat_hold", 0, 3'b111, 4'h0, CTL_LU, 16'hFFFF);
        end
        tick();
        drive_idle();
        tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
